// File: rtl/alu_result_fifo.sv
// alu_result_fifo: result/flag FIFO sitting behind the combinational ALU.
// Stores {data, neg, pos, zero} per entry, valid/ready on both sides,
// first-word-fall-through head presentation.
// Optional feature: define ALU_FLAG_CHECK_EN to build the sticky flag
// consistency checker behind flag_err; otherwise flag_err is tied low.
module alu_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_neg,
  input  logic                       in_pos,
  input  logic                       in_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_neg,
  output logic                       out_pos,
  output logic                       out_zero,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       flag_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = WIDTH + 3;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic [ENT_W-1:0] head;
  logic             push;
  logic             pop;

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Status comes only from the occupancy register, so no input reaches
  // in_ready/out_valid combinationally. A pop while full does not open
  // in_ready in the same cycle.
  assign full      = (cnt_q == CNT_FULL);
  assign empty     = (cnt_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = cnt_q;

  assign push = in_valid && !full;
  assign pop  = out_ready && !empty;

  // Entry storage; contents are not reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_data, in_neg, in_pos, in_zero};
    end
  end

  // Write and read pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Head presentation, forced to zero while empty so stale storage never leaks.
  always_comb begin
    head = mem[rd_ptr];
    if (empty) begin
      out_data = '0;
      out_neg  = 1'b0;
      out_pos  = 1'b0;
      out_zero = 1'b0;
    end else begin
      out_data = head[ENT_W-1:3];
      out_neg  = head[2];
      out_pos  = head[1];
      out_zero = head[0];
    end
  end

`ifdef ALU_FLAG_CHECK_EN
  logic flag_bad;
  logic err_q;
  logic one_hot;
  logic data_zero;

  // Flags must be exactly one-hot and agree with the sign/zero of the data.
  always_comb begin
    data_zero = (in_data == '0);
    one_hot   = ({in_neg, in_pos, in_zero} == 3'b100) ||
                ({in_neg, in_pos, in_zero} == 3'b010) ||
                ({in_neg, in_pos, in_zero} == 3'b001);
    flag_bad  = !one_hot ||
                (in_zero != data_zero) ||
                (in_neg != (in_data[WIDTH-1] && !data_zero));
  end

  // Sticky error, only evaluated on accepted pushes; the entry is kept as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (push && flag_bad) begin
      err_q <= 1'b1;
    end
  end

  assign flag_err = err_q;
`else
  assign flag_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: table vectors, hand sequences for corner cases
// and randomized traffic against a queue-based reference model.
module tb_alu_result_fifo;

`ifdef ALU_FLAG_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0, in_ready, in_neg = 1'b0, in_pos = 1'b0, in_zero = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_valid, out_ready = 1'b0, out_neg, out_pos, out_zero;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       full, empty, flag_err;

  logic       in_valid3 = 1'b0, in_ready3, in_neg3 = 1'b0, in_pos3 = 1'b0, in_zero3 = 1'b0;
  logic [7:0] in_data3 = '0;
  logic       out_valid3, out_ready3 = 1'b0, out_neg3, out_pos3, out_zero3;
  logic [7:0] out_data3;
  logic [1:0] count3;
  logic       full3, empty3, flag_err3;

  int n_checks = 0;
  int n_fail = 0;

  logic [10:0] q[$];
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  alu_result_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_neg(in_neg), .in_pos(in_pos), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_neg(out_neg), .out_pos(out_pos), .out_zero(out_zero),
    .count(count), .full(full), .empty(empty), .flag_err(flag_err)
  );

  alu_result_fifo #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .in_neg(in_neg3), .in_pos(in_pos3), .in_zero(in_zero3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_neg(out_neg3), .out_pos(out_pos3), .out_zero(out_zero3),
    .count(count3), .full(full3), .empty(empty3), .flag_err(flag_err3)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [2:0] f;
    logic       r;
    int         exp_cnt;
    logic       exp_ov;
    logic [7:0] exp_od;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec flag rule: zero if data==0, neg if msb set, otherwise pos.
  function automatic logic [2:0] flags_of(input logic [7:0] d);
    if (d == 8'h00) return 3'b001;
    if (d[7])       return 3'b100;
    return 3'b010;
  endfunction

  task automatic check_model();
    logic [10:0] h;
    h = (q.size() > 0) ? q[0] : 11'h0;
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    chk("in_ready",  {31'b0, in_ready},  {31'b0, q.size() < 4});
    chk("count",     {29'b0, count},     q.size());
    chk("full",      {31'b0, full},      {31'b0, q.size() == 4});
    chk("empty",     {31'b0, empty},     {31'b0, q.size() == 0});
    chk("out_data",  {24'b0, out_data},  {24'b0, h[10:3]});
    chk("out_flags", {29'b0, out_neg, out_pos, out_zero}, {29'b0, h[2:0]});
    chk("flag_err",  {31'b0, flag_err},  {31'b0, exp_err});
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic [2:0] f, input logic r);
    logic do_push, do_pop;
    in_valid = v;
    in_data  = d;
    {in_neg, in_pos, in_zero} = f;
    out_ready = r;
    do_push = v && (q.size() < 4);
    do_pop  = r && (q.size() > 0);
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      q.push_back({d, f});
      if (ERR_EN && (f != flags_of(d))) exp_err = 1'b1;
    end
    check_model();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    q.delete();
    exp_err = 1'b0;
    check_model();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h05, 3'b010, 1'b0, 1, 1'b1, 8'h05};
    tbl[1]  = '{1'b0, 8'h00, 3'b000, 1'b1, 0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h01, 3'b010, 1'b0, 1, 1'b1, 8'h01};
    tbl[3]  = '{1'b1, 8'h02, 3'b010, 1'b0, 2, 1'b1, 8'h01};
    tbl[4]  = '{1'b1, 8'h03, 3'b010, 1'b0, 3, 1'b1, 8'h01};
    tbl[5]  = '{1'b1, 8'h04, 3'b010, 1'b0, 4, 1'b1, 8'h01};
    tbl[6]  = '{1'b1, 8'hAA, 3'b100, 1'b1, 3, 1'b1, 8'h02};
    tbl[7]  = '{1'b1, 8'hAA, 3'b100, 1'b0, 4, 1'b1, 8'h02};
    tbl[8]  = '{1'b0, 8'h00, 3'b000, 1'b1, 3, 1'b1, 8'h03};
    tbl[9]  = '{1'b0, 8'h00, 3'b000, 1'b1, 2, 1'b1, 8'h04};
    tbl[10] = '{1'b0, 8'h00, 3'b000, 1'b1, 1, 1'b1, 8'hAA};
    tbl[11] = '{1'b0, 8'h00, 3'b000, 1'b1, 0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 8'h00, 3'b000, 1'b1, 0, 1'b0, 8'h00};

    #12 rst_n = 1'b1;
    check_model();
    chk("reset_in_ready3", {31'b0, in_ready3}, 32'd1);
    chk("reset_count3", {30'b0, count3}, 32'd0);

    // Directed vectors: single word latency, fill/drain order, full + pop.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      chk($sformatf("tbl%0d_count", i), {29'b0, count}, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_ov", i), {31'b0, out_valid}, {31'b0, tbl[i].exp_ov});
      chk($sformatf("tbl%0d_od", i), {24'b0, out_data}, {24'b0, tbl[i].exp_od});
    end

    // Inconsistent flags: 0x80 tagged pos.
    step(1'b1, 8'h80, 3'b010, 1'b0);
    chk("flag_err_set", {31'b0, flag_err}, {31'b0, ERR_EN});
    chk("bad_entry_kept", {24'b0, out_data}, 32'h80);
    chk("bad_entry_pos", {31'b0, out_pos}, 32'd1);
    step(1'b0, 8'h00, 3'b000, 1'b1);
    step(1'b1, 8'h07, 3'b010, 1'b1);
    chk("flag_err_sticky", {31'b0, flag_err}, {31'b0, ERR_EN});
    step(1'b0, 8'h00, 3'b000, 1'b1);
    pulse_reset();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      logic [2:0] f;
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) d = 8'h00;
      f = ($urandom_range(0, 15) == 0) ? 3'($urandom) : flags_of(d);
      step($urandom_range(0, 3) != 0, d, f, $urandom_range(0, 2) != 0);
    end
    step(1'b0, 8'h00, 3'b000, 1'b1);
    step(1'b0, 8'h00, 3'b000, 1'b1);
    step(1'b0, 8'h00, 3'b000, 1'b1);
    step(1'b0, 8'h00, 3'b000, 1'b1);
    pulse_reset();

    // Asynchronous reset with two entries held.
    step(1'b1, 8'h11, 3'b010, 1'b0);
    step(1'b1, 8'h22, 3'b010, 1'b0);
    chk("pre_reset_count", {29'b0, count}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", {29'b0, count}, 32'd0);
    chk("async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_in_ready", {31'b0, in_ready}, 32'd1);
    chk("async_out_data", {24'b0, out_data}, 32'd0);
    q.delete();
    exp_err = 1'b0;
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step(1'b0, 8'h00, 3'b000, 1'b1);

    // DEPTH=3 streaming across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] w;
      w = 8'(8'h30 + i * 7);
      in_valid3 = 1'b1;
      in_data3 = w;
      {in_neg3, in_pos3, in_zero3} = flags_of(w);
      out_ready3 = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("d3_ov%0d", i), {31'b0, out_valid3}, 32'd1);
      chk($sformatf("d3_data%0d", i), {24'b0, out_data3}, {24'b0, w});
      chk($sformatf("d3_count%0d", i), {30'b0, count3}, 32'd1);
    end
    in_valid3 = 1'b0;
    @(posedge clk);
    #1;
    chk("d3_drained", {31'b0, empty3}, 32'd1);

    // DEPTH=3 fill/drain with stalled consumer, then wrap again.
    out_ready3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid3 = 1'b1;
      in_data3 = 8'(8'h50 + i);
      {in_neg3, in_pos3, in_zero3} = 3'b010;
      @(posedge clk);
      #1;
    end
    chk("d3_full", {31'b0, full3}, 32'd1);
    chk("d3_full_count", {30'b0, count3}, 32'd3);
    in_valid3 = 1'b0;
    out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d3_drain%0d", i), {24'b0, out_data3}, 32'h50 + i);
      @(posedge clk);
      #1;
    end
    chk("d3_empty", {31'b0, empty3}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
